dpram_rd_ctrl: RTL

DPRAM_RD_CTRL -- requirements
Module: dpram_rd_ctrl

---
 rtl/dpram_rd_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dpram_rd_ctrl.sv
// Reads Len bytes from a dual-port RAM read port and hands them one at a time to a UART byte transmitter.
// Optional Tx_done watchdog is enabled by defining DPRAM_RD_TIMEOUT_EN.
module dpram_rd_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W:0]   Len,
    output logic [ADDR_W-1:0] Rd_addr,
    input  logic [7:0]        Rd_data,
    output logic              Tx_en,
    output logic [7:0]        Tx_data,
    input  logic              Tx_done,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    if (RD_LAT < 1 || RD_LAT > 3 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("dpram_rd_ctrl: RD_LAT must be 1..3 and TIMEOUT_CYC at least 1");
    end

    typedef enum logic [2:0] {IDLE, RD_WAIT, SEND, TX_WAIT, NEXT} state_t;

    localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    state_t            state_n;
    logic [1:0]        wait_cnt;
    logic [ADDR_W:0]   byte_cnt;
    logic [ADDR_W:0]   len_q;
    logic              start_acc;
    logic              busy_n;
    logic              tx_en_n;
    logic              done_n;

`ifdef DPRAM_RD_TIMEOUT_EN
    localparam int            WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_n;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        busy_n    = Busy;
        tx_en_n   = 1'b0;
        done_n    = 1'b0;
        start_acc = 1'b0;
`ifdef DPRAM_RD_TIMEOUT_EN
        err_n     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        start_acc = 1'b1;
                        busy_n    = 1'b1;
                        state_n   = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (wait_cnt == WAIT_LAST) state_n = SEND;
            end
            SEND: begin
                tx_en_n = 1'b1;
                state_n = TX_WAIT;
            end
            TX_WAIT: begin
                // Tx_en is high on the first TX_WAIT cycle; a Tx_done then belongs to nothing we sent
                if (Tx_done && !Tx_en) begin
                    state_n = NEXT;
                end
`ifdef DPRAM_RD_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
`endif
            end
            NEXT: begin
                if (byte_cnt + CNT_ONE == len_q) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    state_n = RD_WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rd_addr  <= '0;
            Tx_data  <= '0;
            Tx_en    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            wait_cnt <= '0;
            byte_cnt <= '0;
            len_q    <= '0;
        end else begin
            Tx_en    <= tx_en_n;
            Busy     <= busy_n;
            Done     <= done_n;
            wait_cnt <= (state == RD_WAIT) ? wait_cnt + 2'd1 : 2'd0;
            if (start_acc) begin
                len_q    <= Len;
                byte_cnt <= '0;
                Rd_addr  <= '0;
            end
            // Capture on the SEND edge so Tx_data is valid together with Tx_en
            if (state == SEND) Tx_data <= Rd_data;
            // The last byte leaves Rd_addr alone so a full-depth transfer never wraps
            if (state == NEXT) begin
                byte_cnt <= byte_cnt + CNT_ONE;
                if (state_n == RD_WAIT) Rd_addr <= Rd_addr + ADDR_ONE;
            end
        end
    end

`ifdef DPRAM_RD_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wd_cnt <= '0;
            Err    <= 1'b0;
        end else begin
            wd_cnt <= (state == TX_WAIT) ? wd_cnt + WD_ONE : '0;
            Err    <= err_n;
        end
    end
`else
    assign Err = 1'b0;
`endif

endmodule
